// File: rtl/button_event_arbiter.sv
// Four push-buttons -> synchronized, debounced, edge-detected presses, shared
// onto one valid/ack event channel by a round-robin arbiter (1=U 2=R 3=D 4=L).
module button_event_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [3:0] held,
  output logic       dropped
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [3:0]       btn_raw;
  logic [3:0]       s1, s2;
  logic [3:0]       held_d;
  logic [3:0]       press;
  logic [3:0]       pending;
  logic [3:0]       pending_nxt;
  logic [3:0]       grant_oh;
  logic             drop_nxt;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       rr_last;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_any;

  assign btn_raw = {BTNL, BTND, BTNR, BTNU};
  assign press   = held & ~held_d;

  // Cyclic search starting just after the last winner; offset 4 wraps to rr_last itself.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= 4; off++) begin
      cand = rr_last + 2'(off);
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (state == IDLE && grant_any)
      grant_oh[grant_idx] = 1'b1;
  end

  // A new press always re-arms pending, even when the same button is granted this cycle.
  always_comb begin
    pending_nxt = press | (pending & ~grant_oh);
    drop_nxt    = |(press & pending & ~grant_oh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      held      <= '0;
      held_d    <= '0;
      for (int unsigned i = 0; i < 4; i++)
        cnt[i] <= '0;
      pending   <= '0;
      dropped   <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      rr_last   <= 2'd3;
      state     <= IDLE;
    end else begin
      s1     <= btn_raw;
      s2     <= s1;
      held_d <= held;
      for (int unsigned i = 0; i < 4; i++) begin
        if (s2[i] == held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          held[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      pending <= pending_nxt;
      dropped <= drop_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            evt_valid <= 1'b1;
            evt_code  <= {1'b0, grant_idx} + 3'd1;
            rr_last   <= grant_idx;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (evt_ack) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a short debounce window (4 cycles).
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       BTNU = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNL = 1'b0;
  logic       evt_ack = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [3:0] held;
  logic       dropped;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned drop_cnt = 0;
  logic [2:0]  ev_q[$];
  logic        prev_v = 1'b0;

  button_event_arbiter #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .BTNU(BTNU), .BTNR(BTNR), .BTND(BTND), .BTNL(BTNL),
    .evt_ack(evt_ack), .evt_valid(evt_valid), .evt_code(evt_code),
    .held(held), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Passive monitor: counts dropped pulses and logs each new event code.
  always @(negedge clk) begin
    if (dropped) drop_cnt++;
    if (evt_valid && !prev_v) ev_q.push_back(evt_code);
    prev_v = evt_valid;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {BTNL, BTND, BTNR, BTNU} = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    evt_ack = 1'b0;
    set_btns(4'b0000);
    tick(3);
    reset = 1'b0;
    tick(1);
    ev_q.delete();
  endtask

  task automatic settle();
    set_btns(4'b0000);
    tick(12);
    ev_q.delete();
  endtask

  task automatic get_event(output logic [2:0] code, output bit ok);
    ok = 1'b0;
    code = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (evt_valid) begin
        code = evt_code;
        ok = 1'b1;
      end else begin
        tick(1);
      end
    end
    if (ok) begin
      evt_ack = 1'b1;
      tick(1);
      evt_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++;
    if ({evt_valid, evt_code, held, dropped} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 000000000", {evt_valid, evt_code, held, dropped});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_press();
    ev_q.delete();
    set_btns(4'b0001);
    tick(5);
    n_checks++;
    if (held !== 4'b0000) begin
      n_fail++; $display("FAIL held_early: got %b expected 0000", held);
    end
    tick(1);
    n_checks++;
    if ({held, evt_valid} !== 5'b0001_0) begin
      n_fail++; $display("FAIL held_rise: got %b expected 00010", {held, evt_valid});
    end
    tick(1);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_early: got %b expected 0", evt_valid);
    end
    tick(1);
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b1_001) begin
      n_fail++; $display("FAIL first_event: got %b expected 1001", {evt_valid, evt_code});
    end
    tick(2);
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b1_001) begin
      n_fail++; $display("FAIL event_stable: got %b expected 1001", {evt_valid, evt_code});
    end
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b0_000) begin
      n_fail++; $display("FAIL ack_clear: got %b expected 0000", {evt_valid, evt_code});
    end
    tick(10);
    n_checks++;
    if (ev_q.size() != 1 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_repeat: got %0d events valid=%b expected 1 events valid=0", ev_q.size(), evt_valid);
    end
    set_btns(4'b0000);
    tick(10);
    n_checks++;
    if (held !== 4'b0000 || ev_q.size() != 1) begin
      n_fail++; $display("FAIL release_no_event: got held=%b events=%0d expected held=0000 events=1", held, ev_q.size());
    end
    settle();
  endtask

  task automatic test_bounce();
    int unsigned d0;
    logic [2:0] code;
    bit ok;
    d0 = drop_cnt;
    ev_q.delete();
    for (int seg = 0; seg < 10; seg++) begin
      BTNR = (seg % 2 == 0);
      tick(2);
    end
    n_checks++;
    if (held[1] !== 1'b0 || ev_q.size() != 0) begin
      n_fail++; $display("FAIL bounce_filtered: got held1=%b events=%0d expected 0 0", held[1], ev_q.size());
    end
    BTNR = 1'b1;
    tick(5);
    n_checks++;
    if (held[1] !== 1'b0) begin
      n_fail++; $display("FAIL bounce_held_early: got %b expected 0", held[1]);
    end
    tick(1);
    n_checks++;
    if (held[1] !== 1'b1) begin
      n_fail++; $display("FAIL bounce_held_rise: got %b expected 1", held[1]);
    end
    get_event(code, ok);
    n_checks++;
    if (!ok || code !== 3'd2) begin
      n_fail++; $display("FAIL bounce_code: got ok=%0d code=%0d expected ok=1 code=2", ok, code);
    end
    tick(10);
    n_checks++;
    if (ev_q.size() != 1 || drop_cnt != d0) begin
      n_fail++; $display("FAIL bounce_once: got events=%0d drops=%0d expected 1 0", ev_q.size(), drop_cnt - d0);
    end
    settle();
  endtask

  task automatic test_round_robin();
    logic [2:0] code;
    bit ok;
    logic [2:0] exp2 [2];
    do_reset();
    set_btns(4'b1111);
    for (int i = 0; i < 4; i++) begin
      get_event(code, ok);
      n_checks++;
      if (!ok || code !== 3'(i + 1)) begin
        n_fail++; $display("FAIL rr_all[%0d]: got ok=%0d code=%0d expected code=%0d", i, ok, code, i + 1);
      end
    end
    settle();
    set_btns(4'b0101);
    exp2[0] = 3'd1; exp2[1] = 3'd3;
    for (int i = 0; i < 2; i++) begin
      get_event(code, ok);
      n_checks++;
      if (!ok || code !== exp2[i]) begin
        n_fail++; $display("FAIL rr_ud[%0d]: got ok=%0d code=%0d expected code=%0d", i, ok, code, exp2[i]);
      end
    end
    settle();
    set_btns(4'b0001);
    get_event(code, ok);
    n_checks++;
    if (!ok || code !== 3'd1) begin
      n_fail++; $display("FAIL rr_u: got ok=%0d code=%0d expected code=1", ok, code);
    end
    settle();
    set_btns(4'b0011);
    exp2[0] = 3'd2; exp2[1] = 3'd1;
    for (int i = 0; i < 2; i++) begin
      get_event(code, ok);
      n_checks++;
      if (!ok || code !== exp2[i]) begin
        n_fail++; $display("FAIL rr_ru[%0d]: got ok=%0d code=%0d expected code=%0d", i, ok, code, exp2[i]);
      end
    end
    settle();
  endtask

  task automatic test_dropped();
    int unsigned d0;
    logic [2:0] code;
    bit ok;
    d0 = drop_cnt;
    ev_q.delete();
    set_btns(4'b0100);
    for (int i = 0; i < 40 && !evt_valid; i++) tick(1);
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b1_011) begin
      n_fail++; $display("FAIL drop_first: got %b expected 1011", {evt_valid, evt_code});
    end
    set_btns(4'b0000); tick(10);
    set_btns(4'b0100); tick(10);
    n_checks++;
    if (drop_cnt != d0) begin
      n_fail++; $display("FAIL drop_none_yet: got %0d expected 0", drop_cnt - d0);
    end
    set_btns(4'b0000); tick(10);
    set_btns(4'b0100); tick(10);
    n_checks++;
    if (drop_cnt != d0 + 1) begin
      n_fail++; $display("FAIL drop_once: got %0d expected 1", drop_cnt - d0);
    end
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b1_011) begin
      n_fail++; $display("FAIL drop_held_event: got %b expected 1011", {evt_valid, evt_code});
    end
    get_event(code, ok);
    get_event(code, ok);
    n_checks++;
    if (!ok || code !== 3'd3) begin
      n_fail++; $display("FAIL drop_pending: got ok=%0d code=%0d expected code=3", ok, code);
    end
    tick(15);
    n_checks++;
    if (ev_q.size() != 2 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_total: got events=%0d valid=%b expected 2 0", ev_q.size(), evt_valid);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    logic [2:0] code;
    bit ok;
    do_reset();
    set_btns(4'b1111);
    for (int i = 0; i < 40 && !evt_valid; i++) tick(1);
    n_checks++;
    if ({evt_valid, evt_code} !== 4'b1_001) begin
      n_fail++; $display("FAIL mid_pre: got %b expected 1001", {evt_valid, evt_code});
    end
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid, evt_code, held, dropped} !== 9'b0) begin
      n_fail++; $display("FAIL mid_async_reset: got %b expected 000000000", {evt_valid, evt_code, held, dropped});
    end
    set_btns(4'b0000);
    tick(3);
    reset = 1'b0;
    ev_q.delete();
    tick(20);
    n_checks++;
    if (ev_q.size() != 0 || evt_valid !== 1'b0 || held !== 4'b0000) begin
      n_fail++; $display("FAIL mid_no_stale: got events=%0d valid=%b held=%b expected 0 0 0000", ev_q.size(), evt_valid, held);
    end
    set_btns(4'b0001);
    get_event(code, ok);
    n_checks++;
    if (!ok || code !== 3'd1) begin
      n_fail++; $display("FAIL mid_new_press: got ok=%0d code=%0d expected code=1", ok, code);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [2:0] exp_c;
    do_reset();
    evt_ack = 1'b1;
    set_btns(4'b1111);
    tick(7);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_pre: got %b expected 0", evt_valid);
    end
    for (int j = 0; j < 8; j++) begin
      tick(1);
      exp_v = (j % 2 == 0);
      exp_c = exp_v ? 3'(j / 2 + 1) : 3'd0;
      n_checks++;
      if ({evt_valid, evt_code} !== {exp_v, exp_c}) begin
        n_fail++; $display("FAIL b2b[%0d]: got %b expected %b", j, {evt_valid, evt_code}, {exp_v, exp_c});
      end
    end
    evt_ack = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
